// File: rtl/frame_fetch_ctrl.sv
// frame_fetch_ctrl: fetches pixels from the external framebuffer over the
// reset / next-pixel / 4-bit return interface and buffers them in a small FIFO
// so the VGA side can pop one pixel per pixel clock.
// Optional feature macro: FETCH_PIXEL_REPEAT_EN adds the 4-bit pix_repeat
// input ("repeat" is a reserved word); each entry is then presented
// pix_repeat+1 times before the head advances.
module frame_fetch_ctrl #(
   parameter int PIXEL_W    = 4,
   parameter int DEPTH      = 4,
   parameter int LAT        = 3,
   parameter int STROBE_HI  = 1,
   parameter int RST_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               frame_start,
   output logic               frame_reset_out,
   output logic               frame_next_pixel_out,
   input  logic [PIXEL_W-1:0] frame_pixel_in,
   input  logic               pix_rd,
`ifdef FETCH_PIXEL_REPEAT_EN
   input  logic [3:0]         pix_repeat,
`endif
   output logic [PIXEL_W-1:0] pix_data,
   output logic               pix_empty,
   output logic               underrun
);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam int TW  = 4;
   localparam logic [TW-1:0]  LAT_C    = TW'(LAT);
   localparam logic [TW-1:0]  STB_LAST = TW'(STROBE_HI - 1);
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
   localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);

   typedef enum logic [2:0] {IDLE, RST, CHECK, STROBE, WAIT} state_t;

   state_t             state, next_state;
   logic [RCW-1:0]     rst_cnt;
   logic [TW-1:0]      tcnt;
   logic               restart, push, pop_ok, adv;
   logic               reset_nxt, stb_nxt;
   logic [PIXEL_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count, count_nxt;

   // A frame start always wins; only IDLE honours the enable gate.
   assign restart = frame_start && ((state != IDLE) || enable);
   // The sample lands on the LAT-th cycle after the first strobe cycle.
   assign push    = (state == WAIT) && (tcnt == LAT_C) && !restart;
   assign pop_ok  = pix_rd && (count != '0) && !restart;

`ifdef FETCH_PIXEL_REPEAT_EN
   logic [3:0] rep_cnt;
   assign adv = pop_ok && (rep_cnt == pix_repeat);
`else
   assign adv = pop_ok;
`endif

   assign count_nxt = count + CW'(push) - CW'(adv);

   // State register plus the registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= IDLE;
         frame_reset_out      <= 1'b0;
         frame_next_pixel_out <= 1'b0;
      end else begin
         state                <= next_state;
         frame_reset_out      <= reset_nxt;
         frame_next_pixel_out <= stb_nxt;
      end
   end

   // Next-state decision
   always_comb begin
      next_state = state;
      if (restart) next_state = RST;
      else begin
         case (state)
            IDLE:    next_state = IDLE;
            RST:     if (rst_cnt == RST_LAST) next_state = CHECK;
            CHECK:   if (enable && (count < DEPTH_C)) next_state = STROBE;
            STROBE:  if (tcnt == STB_LAST) next_state = WAIT;
            WAIT:    if (tcnt == LAT_C) next_state = CHECK;
            default: next_state = IDLE;
         endcase
      end
   end

   // Strobe levels follow the state being entered so they are registered
   always_comb begin
      reset_nxt = (next_state == RST);
      stb_nxt   = (next_state == STROBE);
   end

   // Phase counters: reset-pulse length and fetch latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt <= '0;
         tcnt    <= '0;
      end else begin
         if (restart)            rst_cnt <= '0;
         else if (state == RST)  rst_cnt <= rst_cnt + 1'b1;
         if (next_state == STROBE && state != STROBE) tcnt <= '0;
         else if (state == STROBE || state == WAIT)   tcnt <= tcnt + 1'b1;
      end
   end

   // FIFO storage; no reset needed since count guards every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= frame_pixel_in;
   end

   // FIFO pointers, count, head register and sticky underrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pix_data  <= '0;
         pix_empty <= 1'b1;
         underrun  <= 1'b0;
      end else if (restart) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pix_empty <= 1'b1;
         underrun  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) pix_data <= mem[rd_ptr];
         if (adv) rd_ptr <= rd_ptr + 1'b1;
         if (pix_rd && count == '0) underrun <= 1'b1;
         count     <= count_nxt;
         pix_empty <= (count_nxt == '0);
      end
   end

`ifdef FETCH_PIXEL_REPEAT_EN
   // Presentation counter for the current head entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rep_cnt <= '0;
      else if (restart) rep_cnt <= '0;
      else if (adv)     rep_cnt <= '0;
      else if (pop_ok)  rep_cnt <= rep_cnt + 1'b1;
   end
`endif

endmodule
